// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core: FSM states, ISA encodings, ALU ops.
package mc_pkg;

   localparam int unsigned INSTR_W = 32;

   // FSM states, encoded 0..12 in this order
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   // Primary opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // R-type function codes, IR[5:0]
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation selects
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;

   // Map an R-type funct to {known, alu_op}; unknown functs retire as NOPs
   function automatic logic [3:0] decode_funct(input logic [5:0] funct);
      logic [3:0] res;
      case (funct)
         FN_ADD:  res = {1'b1, ALU_ADD};
         FN_SUB:  res = {1'b1, ALU_SUB};
         FN_AND:  res = {1'b1, ALU_AND};
         FN_OR:   res = {1'b1, ALU_OR};
         FN_SLT:  res = {1'b1, ALU_SLT};
         default: res = {1'b0, ALU_ADD};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREGS x WIDTH, two async read ports, one sync write port, r0 hardwired to zero.
module mc_regfile
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 32,
   localparam int unsigned AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd
);

   logic [WIDTH-1:0] regs [NREGS];

   // Clear all entries on reset; writes to r0 are dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_core_hs.sv
// Multicycle MIPS-subset core with an external req/ready memory port, HALT and retire counter.
module mc_core_hs
   import mc_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned RETIRE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic [WIDTH-1:0]    mem_rdata,
   input  logic                mem_ready,
   output logic                halted,
   output logic [3:0]          state,
   output logic [RETIRE_W-1:0] retired
);

   localparam int unsigned RW = $clog2(NREGS);

   state_t               state_r, state_n;
   logic [ADDR_W-1:0]    pc, pc_n;
   logic [INSTR_W-1:0]   ir, ir_n;
   logic [WIDTH-1:0]     a, a_n, b, b_n;
   logic [WIDTH-1:0]     alu_out, alu_n;
   logic [WIDTH-1:0]     mdr, mdr_n;
   logic                 req_n, we_n, halted_n;
   logic [ADDR_W-1:0]    addr_n;
   logic [WIDTH-1:0]     wdata_n;
   logic [RETIRE_W-1:0]  retired_n;
   logic                 retire_inc;

   logic [5:0]           opcode, funct;
   logic [RW-1:0]        rs, rt, rd;
   logic [WIDTH-1:0]     imm_ext;
   logic [WIDTH-1:0]     rd1, rd2;
   logic                 funct_ok;
   logic [2:0]           alu_op;
   logic [WIDTH-1:0]     alu_y;
   logic                 done;

   logic                 rf_we;
   logic [RW-1:0]        rf_wa;
   logic [WIDTH-1:0]     rf_wd;

   // Instruction field extraction; register fields truncated to the register index width
   assign opcode  = ir[31:26];
   assign funct   = ir[5:0];
   assign rs      = ir[21 +: RW];
   assign rt      = ir[16 +: RW];
   assign rd      = ir[11 +: RW];
   assign imm_ext = WIDTH'($signed(ir[15:0]));
   assign {funct_ok, alu_op} = decode_funct(funct);
   assign done    = mem_req && mem_ready;
   assign state   = state_r;

   mc_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rd1),
      .rd2 (rd2),
      .we  (rf_we),
      .wa  (rf_wa),
      .wd  (rf_wd)
   );

   // ALU on the latched A/B operands
   always_comb begin
      alu_y = '0;
      case (alu_op)
         ALU_ADD: alu_y = a + b;
         ALU_SUB: alu_y = a - b;
         ALU_AND: alu_y = a & b;
         ALU_OR:  alu_y = a | b;
         ALU_SLT: alu_y = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         default: alu_y = '0;
      endcase
   end

   // State and datapath registers; memory port outputs are registered so they hold while stalled
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         alu_out   <= '0;
         mdr       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
         retired   <= '0;
      end else begin
         state_r   <= state_n;
         pc        <= pc_n;
         ir        <= ir_n;
         a         <= a_n;
         b         <= b_n;
         alu_out   <= alu_n;
         mdr       <= mdr_n;
         mem_req   <= req_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         halted    <= halted_n;
         retired   <= retired_n;
      end
   end

   // Next-state and datapath control; memory states issue a request then wait for ready
   always_comb begin
      state_n  = state_r;
      pc_n     = pc;
      ir_n     = ir;
      a_n      = a;
      b_n      = b;
      alu_n    = alu_out;
      mdr_n    = mdr;
      req_n    = 1'b0;
      we_n     = 1'b0;
      addr_n   = mem_addr;
      wdata_n  = mem_wdata;
      rf_we    = 1'b0;
      rf_wa    = rt;
      rf_wd    = alu_out;

      case (state_r)
         S_FETCH: begin
            if (done) begin
               ir_n    = INSTR_W'(mem_rdata);
               pc_n    = pc + ADDR_W'(1);
               state_n = S_DECODE;
            end else begin
               req_n  = 1'b1;
               addr_n = pc;
            end
         end
         S_DECODE: begin
            a_n   = rd1;
            b_n   = rd2;
            alu_n = WIDTH'(pc) + imm_ext;
            case (opcode)
               OP_RTYPE: state_n = funct_ok ? S_EXECUTE : S_FETCH;
               OP_LW,
               OP_SW:    state_n = S_MEMADR;
               OP_ADDI:  state_n = S_ADDIEX;
               OP_BEQ:   state_n = S_BRANCH;
               OP_J:     state_n = S_JUMP;
               OP_HALT:  state_n = S_HALT;
               default:  state_n = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_n   = a + imm_ext;
            state_n = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            if (done) begin
               mdr_n   = mem_rdata;
               state_n = S_MEMWB;
            end else begin
               req_n  = 1'b1;
               addr_n = alu_out[ADDR_W-1:0];
            end
         end
         S_MEMWB: begin
            rf_we   = 1'b1;
            rf_wa   = rt;
            rf_wd   = mdr;
            state_n = S_FETCH;
         end
         S_MEMWRITE: begin
            if (done) begin
               state_n = S_FETCH;
            end else begin
               req_n   = 1'b1;
               we_n    = 1'b1;
               addr_n  = alu_out[ADDR_W-1:0];
               wdata_n = b;
            end
         end
         S_EXECUTE: begin
            alu_n   = alu_y;
            state_n = S_ALUWB;
         end
         S_ALUWB: begin
            rf_we   = 1'b1;
            rf_wa   = rd;
            rf_wd   = alu_out;
            state_n = S_FETCH;
         end
         S_BRANCH: begin
            if (a == b) begin
               pc_n = alu_out[ADDR_W-1:0];
            end
            state_n = S_FETCH;
         end
         S_ADDIEX: begin
            alu_n   = a + imm_ext;
            state_n = S_ADDIWB;
         end
         S_ADDIWB: begin
            rf_we   = 1'b1;
            rf_wa   = rt;
            rf_wd   = alu_out;
            state_n = S_FETCH;
         end
         S_JUMP: begin
            pc_n    = ADDR_W'(ir[25:0]);
            state_n = S_FETCH;
         end
         S_HALT: begin
            state_n = S_HALT;
         end
         default: begin
            state_n = S_FETCH;
         end
      endcase

      halted_n   = (state_n == S_HALT);
      retire_inc = ((state_n == S_FETCH) && (state_r != S_FETCH)) ||
                   ((state_n == S_HALT)  && (state_r != S_HALT));
      retired_n  = retired + RETIRE_W'(retire_inc);
   end

endmodule
